// File: rtl/sr_mem_arbiter.sv
// Round-robin arbiter that serialises N_REQ requesters onto one memory port, one transaction
// outstanding at a time. Define SR_ARB_TIMEOUT_EN to enable the response watchdog.

module sr_mem_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_wr_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*16-1:0]      req_addr_i,
  input  logic [N_REQ*32-1:0]      req_wdata_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REQ-1:0]         resp_valid_o,
  input  logic [N_REQ-1:0]         resp_ready_i,
  output logic [31:0]              resp_rdata_o,
  output logic                     resp_err_o,
  output logic                     mem_wr_o,
  output logic [15:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  input  logic                     mem_resp_valid_i,
  output logic                     mem_resp_ready_o,
  input  logic [31:0]              mem_rdata_i,
  output logic                     busy_o,
  output logic [$clog2(N_REQ)-1:0] grant_o
);

  localparam int unsigned GW = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("sr_mem_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sr_mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last_grant;
  logic [31:0]   r_rdata;
  logic [GW-1:0] w_arb_idx;
  logic          w_arb_hit;
  logic          w_timeout;

  logic [15:0] w_addr_arr  [N_REQ];
  logic [31:0] w_wdata_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_slice
    assign w_addr_arr[k]  = req_addr_i[k*16 +: 16];
    assign w_wdata_arr[k] = req_wdata_i[k*32 +: 32];
  end

  // Search starts one past the last served requester so every requester waits at most N_REQ turns.
  always_comb begin
    w_arb_idx = r_grant;
    w_arb_hit = 1'b0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      if (!w_arb_hit && req_valid_i[GW'((int'(r_last_grant) + i) % int'(N_REQ))]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = GW'((int'(r_last_grant) + i) % int'(N_REQ));
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_arb_hit)                      w_state_nxt = ST_ISSUE;
      ST_ISSUE:   if (mem_req_ready_i)                w_state_nxt = ST_WAIT;
      ST_WAIT:    if (mem_resp_valid_i || w_timeout)  w_state_nxt = ST_DELIVER;
      ST_DELIVER: if (resp_ready_i[r_grant])          w_state_nxt = ST_IDLE;
      default:                                        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(N_REQ - 1);
      r_rdata      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_arb_hit) begin
        r_grant <= w_arb_idx;
      end
      if (r_state == ST_DELIVER && resp_ready_i[r_grant]) begin
        r_last_grant <= r_grant;
      end
      // A real response in the final watchdog cycle takes priority over the timeout.
      if (r_state == ST_WAIT && mem_resp_valid_i) begin
        r_rdata <= mem_rdata_i;
      end else if (w_timeout) begin
        r_rdata <= '0;
      end
    end
  end

`ifdef SR_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_timeout = (r_state == ST_WAIT) && !mem_resp_valid_i &&
                     (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != ST_WAIT) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == ST_WAIT && mem_resp_valid_i) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign resp_err_o = r_err;
`else
  assign w_timeout  = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    if (r_state == ST_ISSUE) begin
      req_ready_o[r_grant] = mem_req_ready_i;
    end
    if (r_state == ST_DELIVER) begin
      resp_valid_o[r_grant] = 1'b1;
    end
  end

  assign mem_req_valid_o  = (r_state == ST_ISSUE);
  assign mem_wr_o         = req_wr_i[r_grant];
  assign mem_addr_o       = w_addr_arr[r_grant];
  assign mem_wdata_o      = w_wdata_arr[r_grant];
  assign mem_resp_ready_o = (r_state == ST_WAIT);
  assign resp_rdata_o     = r_rdata;
  assign busy_o           = (r_state != ST_IDLE);
  assign grant_o          = r_grant;

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Directed bench for sr_mem_arbiter (4 requesters); the watchdog scenario runs only when
// SR_ARB_TIMEOUT_EN is defined.

module tb_sr_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_wr, req_valid, resp_ready;
  logic [63:0]  req_addr;
  logic [127:0] req_wdata;
  logic         mem_req_ready, mem_resp_valid;
  logic [31:0]  mem_rdata;

  logic [3:0]   req_ready_o, resp_valid_o;
  logic [31:0]  resp_rdata_o, mem_wdata_o;
  logic         resp_err_o, mem_wr_o, mem_req_valid_o, mem_resp_ready_o, busy_o;
  logic [15:0]  mem_addr_o;
  logic [1:0]   grant_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sr_mem_arbiter #(
    .N_REQ          (4),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .req_wr_i         (req_wr),
    .req_valid_i      (req_valid),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .req_ready_o      (req_ready_o),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready),
    .resp_rdata_o     (resp_rdata_o),
    .resp_err_o       (resp_err_o),
    .mem_wr_o         (mem_wr_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_rdata_i      (mem_rdata),
    .busy_o           (busy_o),
    .grant_o          (grant_o)
  );

  // Advance to 1ns after the next rising edge(s).
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    req_wr         = '0;
    req_valid      = '0;
    resp_ready     = '0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cyc(2);
    #1;
    n_checks++;
    if ({busy_o, mem_req_valid_o, mem_resp_ready_o, resp_err_o, req_ready_o, resp_valid_o}
        !== 12'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want 0", {busy_o, mem_req_valid_o, mem_resp_ready_o,
               resp_err_o, req_ready_o, resp_valid_o});
    end
    n_checks++;
    if ({grant_o, resp_rdata_o} !== 34'b0) begin
      n_errors++;
      $display("FAIL reset_grant_rdata: got grant %0d rdata %h want 0/0", grant_o, resp_rdata_o);
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_single_read();
    req_addr[16 +: 16] = 16'h1004;
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if ({busy_o, mem_req_valid_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL read_idle_quiet: got %b want 00", {busy_o, mem_req_valid_o});
    end
    cyc(1);
    #1;
    n_checks++;
    if ({mem_req_valid_o, mem_wr_o, mem_addr_o, grant_o, req_ready_o} !==
        {1'b1, 1'b0, 16'h1004, 2'd1, 4'b0000}) begin
      n_errors++;
      $display("FAIL read_issue: got v%b wr%b addr %h grant %0d rdy %b want v1 wr0 1004 1 0000",
               mem_req_valid_o, mem_wr_o, mem_addr_o, grant_o, req_ready_o);
    end
    cyc(2);
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0010) begin
      n_errors++;
      $display("FAIL read_req_ready: got %b want 0010", req_ready_o);
    end
    cyc(1);
    mem_req_ready = 1'b0;
    req_valid     = '0;
    #1;
    n_checks++;
    if ({mem_resp_ready_o, mem_req_valid_o, busy_o} !== 3'b101) begin
      n_errors++;
      $display("FAIL read_wait: got %b want 101", {mem_resp_ready_o, mem_req_valid_o, busy_o});
    end
    cyc(4);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hA5A5_1234;
    #1;
    n_checks++;
    if (resp_valid_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL read_early_resp: got %b want 0000", resp_valid_o);
    end
    cyc(1);
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    #1;
    n_checks++;
    if ({resp_valid_o, resp_rdata_o, resp_err_o, mem_resp_ready_o} !==
        {4'b0010, 32'hA5A5_1234, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL read_deliver: got %b %h err%b rr%b want 0010 a5a51234 err0 rr0",
               resp_valid_o, resp_rdata_o, resp_err_o, mem_resp_ready_o);
    end
    resp_ready = 4'b0010;
    cyc(1);
    resp_ready = '0;
    #1;
    n_checks++;
    if ({busy_o, resp_valid_o, resp_rdata_o} !== {1'b0, 4'b0000, 32'hA5A5_1234}) begin
      n_errors++;
      $display("FAIL read_done: got busy%b %b %h want busy0 0000 a5a51234",
               busy_o, resp_valid_o, resp_rdata_o);
    end
  endtask

  task automatic test_round_robin();
    int got [5];
    int exp_g [5];
    int n = 0;
    exp_g = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    cyc(1);
    rst            = 1'b0;
    req_valid      = 4'b1111;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h5555_AAAA;
    resp_ready     = 4'b1111;
    for (int c = 0; c < 40 && n < 5; c++) begin
      cyc(1);
      #1;
      if (mem_req_valid_o) begin
        got[n] = int'(grant_o);
        n++;
      end
    end
    n_checks++;
    if (n != 5) begin
      n_errors++;
      $display("FAIL rr_grant_count: got %0d want 5", n);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (got[i] != exp_g[i]) begin
        n_errors++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, got[i], exp_g[i]);
      end
    end
    req_valid = '0;
    cyc(3);
    idle_inputs();
    #1;
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rr_drain: got busy %b want 0", busy_o);
    end
  endtask

  task automatic test_backpressure();
    req_addr   = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    req_wdata  = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
    req_wr     = 4'b0100;
    req_valid  = 4'b0100;
    cyc(1);
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if ({mem_req_valid_o, mem_wr_o, mem_addr_o, mem_wdata_o, req_ready_o} !==
          {1'b1, 1'b1, 16'hBEEF, 32'h1234_5678, 4'b0000}) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got v%b wr%b %h %h rdy %b want v1 wr1 beef 12345678 0000",
                 c, mem_req_valid_o, mem_wr_o, mem_addr_o, mem_wdata_o, req_ready_o);
      end
      cyc(1);
    end
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0100) begin
      n_errors++;
      $display("FAIL bp_release: got %b want 0100", req_ready_o);
    end
    cyc(1);
    mem_req_ready  = 1'b0;
    req_valid      = '0;
    req_wr         = '0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hDEAD_0001;
    cyc(1);
    mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid_o, resp_rdata_o} !== {4'b0100, 32'hDEAD_0001}) begin
      n_errors++;
      $display("FAIL bp_deliver: got %b %h want 0100 dead0001", resp_valid_o, resp_rdata_o);
    end
    resp_ready = 4'b0100;
    cyc(1);
    resp_ready = '0;
  endtask

  task automatic test_stray_resp();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hFFFF_0000;
    cyc(2);
    #1;
    n_checks++;
    if ({busy_o, resp_valid_o, mem_resp_ready_o, resp_rdata_o} !==
        {1'b0, 4'b0000, 1'b0, 32'hDEAD_0001}) begin
      n_errors++;
      $display("FAIL stray_idle: got busy%b %b rr%b %h want busy0 0000 rr0 dead0001",
               busy_o, resp_valid_o, mem_resp_ready_o, resp_rdata_o);
    end
    req_valid = 4'b1000;
    cyc(2);
    #1;
    n_checks++;
    if ({mem_req_valid_o, grant_o, mem_resp_ready_o, resp_valid_o, resp_rdata_o} !==
        {1'b1, 2'd3, 1'b0, 4'b0000, 32'hDEAD_0001}) begin
      n_errors++;
      $display("FAIL stray_issue: got v%b g%0d rr%b %b %h want v1 g3 rr0 0000 dead0001",
               mem_req_valid_o, grant_o, mem_resp_ready_o, resp_valid_o, resp_rdata_o);
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    cyc(1);
    mem_req_ready  = 1'b0;
    req_valid      = '0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0BAD_F00D;
    cyc(1);
    mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid_o, resp_rdata_o} !== {4'b1000, 32'h0BAD_F00D}) begin
      n_errors++;
      $display("FAIL stray_final: got %b %h want 1000 0badf00d", resp_valid_o, resp_rdata_o);
    end
    resp_ready = 4'b1000;
    cyc(1);
    resp_ready = '0;
  endtask

  task automatic test_reset_mid();
    req_valid     = 4'b0010;
    mem_req_ready = 1'b1;
    cyc(2);
    mem_req_ready = 1'b0;
    req_valid     = '0;
    #1;
    n_checks++;
    if (mem_resp_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_in_wait: got rr %b want 1", mem_resp_ready_o);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, mem_req_valid_o, mem_resp_ready_o, resp_valid_o, req_ready_o, resp_err_o,
         grant_o, resp_rdata_o} !== 45'b0) begin
      n_errors++;
      $display("FAIL rmid_async: got busy%b v%b rr%b %b %b err%b g%0d %h want all 0",
               busy_o, mem_req_valid_o, mem_resp_ready_o, resp_valid_o, req_ready_o,
               resp_err_o, grant_o, resp_rdata_o);
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h7777_7777;
    cyc(1);
    rst            = 1'b0;
    mem_resp_valid = 1'b0;
    cyc(1);
    #1;
    n_checks++;
    if ({busy_o, resp_valid_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL rmid_abandon: got busy%b %b want busy0 0000", busy_o, resp_valid_o);
    end
    req_valid = 4'b0101;
    cyc(1);
    #1;
    n_checks++;
    if ({mem_req_valid_o, grant_o} !== {1'b1, 2'd0}) begin
      n_errors++;
      $display("FAIL rmid_grant: got v%b g%0d want v1 g0", mem_req_valid_o, grant_o);
    end
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready  = 1'b0;
    req_valid      = '0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h00C0_FFEE;
    cyc(1);
    mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid_o, resp_rdata_o} !== {4'b0001, 32'h00C0_FFEE}) begin
      n_errors++;
      $display("FAIL rmid_final: got %b %h want 0001 00c0ffee", resp_valid_o, resp_rdata_o);
    end
    resp_ready = 4'b0001;
    cyc(1);
    resp_ready = '0;
  endtask

`ifdef SR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_valid     = 4'b0001;
    mem_req_ready = 1'b1;
    cyc(2);
    mem_req_ready = 1'b0;
    req_valid     = '0;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_checks++;
      if (resp_valid_o !== 4'b0000) begin
        n_errors++;
        $display("FAIL to_wait[%0d]: got %b want 0000", c, resp_valid_o);
      end
      cyc(1);
    end
    #1;
    n_checks++;
    if ({resp_valid_o, resp_rdata_o, resp_err_o} !== {4'b0001, 32'h0, 1'b1}) begin
      n_errors++;
      $display("FAIL to_fire: got %b %h err%b want 0001 0 err1",
               resp_valid_o, resp_rdata_o, resp_err_o);
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    cyc(1);
    mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid_o, resp_rdata_o, resp_err_o} !== {4'b0001, 32'h0, 1'b1}) begin
      n_errors++;
      $display("FAIL to_late: got %b %h err%b want 0001 0 err1",
               resp_valid_o, resp_rdata_o, resp_err_o);
    end
    resp_ready = 4'b0001;
    cyc(1);
    resp_ready = '0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL to_done: got busy %b want 0", busy_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_stray_resp();
    test_reset_mid();
`ifdef SR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
